// File: rtl/reindeer_wb_uart_tx_pkg.sv
// Shared definitions for the Wishbone UART transmitter.
// Contents: register word offsets relative to BASE_ADDR, STATUS bit positions,
// and the transmit FSM state type.
package reindeer_wb_uart_tx_pkg;

  // Register word offsets
  localparam int unsigned DATA_OFS   = 0;
  localparam int unsigned STATUS_OFS = 1;

  // STATUS register layout
  localparam int unsigned ST_BUSY_BIT  = 0;
  localparam int unsigned ST_FULL_BIT  = 1;
  localparam int unsigned ST_EMPTY_BIT = 2;
  localparam int unsigned ST_OVF_BIT   = 3;
  localparam int unsigned ST_CNT_LSB   = 4;
  localparam int unsigned ST_CNT_W     = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_e;

endpackage

// File: rtl/reindeer_sync_fifo.sv
// Synchronous first-word-fall-through FIFO.
// Ports: clk, reset (async, active-high), clr (sync clear), push/push_data,
// pop/pop_data (pop_data shows the head entry whenever not empty),
// full, empty, count (0..DEPTH).
// Pushes while full and pops while empty are ignored, so callers may drive
// push/pop freely and read full/empty for their own bookkeeping.
module reindeer_sync_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       clr,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push & ~full & ~clr;
  assign do_pop  = pop & ~empty & ~clr;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; that is what keeps synthesis from inferring a latch.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // Pointers wrap naturally because DEPTH is a power of two.
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: the storage array has no reset; occupancy is tracked by the
  // pointers and count, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

  assign pop_data = mem_q[rd_ptr_q];
  assign count    = count_q;

endmodule

// File: rtl/reindeer_wb_uart_tx.sv
// Wishbone-attached UART transmitter (8N1, LSB first) with a TX FIFO.
// Ports: clk, reset (async, active-high), sync_reset (same effect, sync);
// Wishbone read port (WB_RD_*) and write port (WB_WR_*), one word address
// each; TXD serial output (idles high).
// Registers: DATA at BASE_ADDR (write pushes a byte, reads 0),
// STATUS at BASE_ADDR+1 (busy, full, empty, sticky overflow, FIFO count).
module reindeer_wb_uart_tx
  import reindeer_wb_uart_tx_pkg::*;
#(
  parameter int unsigned BAUD_DIV         = 868,
  parameter int unsigned FIFO_DEPTH       = 8,
  parameter int unsigned BASE_ADDR        = 8'h10,
  parameter int unsigned MM_REG_ADDR_BITS = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        sync_reset,
  input  logic                        WB_RD_CYC_I,
  input  logic                        WB_RD_STB_I,
  input  logic [MM_REG_ADDR_BITS-1:0] WB_RD_ADR_I,
  output logic [31:0]                 WB_RD_DAT_O,
  output logic                        WB_RD_ACK_O,
  input  logic                        WB_WR_CYC_I,
  input  logic                        WB_WR_STB_I,
  input  logic                        WB_WR_WE_I,
  input  logic [3:0]                  WB_WR_SEL_I,
  input  logic [MM_REG_ADDR_BITS-1:0] WB_WR_ADR_I,
  input  logic [31:0]                 WB_WR_DAT_I,
  output logic                        WB_WR_ACK_O,
  output logic                        TXD
);

  localparam int unsigned CNT_W = $clog2(BAUD_DIV);
  localparam int unsigned FCW   = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(BAUD_DIV - 1);
  localparam logic [MM_REG_ADDR_BITS-1:0] DATA_ADDR   = MM_REG_ADDR_BITS'(BASE_ADDR + DATA_OFS);
  localparam logic [MM_REG_ADDR_BITS-1:0] STATUS_ADDR = MM_REG_ADDR_BITS'(BASE_ADDR + STATUS_OFS);

  // Bus decode
  logic wr_req, wr_hit_data, wr_hit_status, wr_accept;
  logic rd_accept, rd_is_status;
  logic push_req, ovf_set;

  // FIFO interface
  logic           fifo_pop, fifo_full, fifo_empty;
  logic [7:0]     fifo_rdata;
  logic [FCW-1:0] fifo_count;

  // Register-file flops
  logic        wr_ack_q, wr_ack_d;
  logic        rd_ack_q, rd_ack_d;
  logic [31:0] rd_dat_q, rd_dat_d;
  logic        ovf_q, ovf_d;
  logic [31:0] status_word;

  // Transmit FSM flops
  tx_state_e        state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       bit_idx_q;
  logic [7:0]       shift_q;
  logic             txd_q;

  // Only the low byte and its lane select carry meaning for DATA writes.
  logic unused_wr_bits;
  assign unused_wr_bits = ^{WB_WR_DAT_I[31:8], WB_WR_SEL_I[3:1]};

  assign wr_req        = WB_WR_CYC_I & WB_WR_STB_I & WB_WR_WE_I;
  assign wr_hit_data   = wr_req & (WB_WR_ADR_I == DATA_ADDR);
  assign wr_hit_status = wr_req & (WB_WR_ADR_I == STATUS_ADDR);
  assign wr_accept     = wr_hit_data | wr_hit_status;

  assign rd_is_status  = (WB_RD_ADR_I == STATUS_ADDR);
  assign rd_accept     = WB_RD_CYC_I & WB_RD_STB_I &
                         ((WB_RD_ADR_I == DATA_ADDR) | rd_is_status);

  // A full FIFO rejects the byte even if the FSM pops on the same edge.
  assign push_req = wr_hit_data & WB_WR_SEL_I[0] & ~sync_reset;
  assign ovf_set  = push_req & fifo_full;
  assign fifo_pop = (state_q == IDLE) & ~fifo_empty & ~sync_reset;

  reindeer_sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .clr       (sync_reset),
    .push      (push_req),
    .push_data (WB_WR_DAT_I[7:0]),
    .pop       (fifo_pop),
    .pop_data  (fifo_rdata),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_comb begin
    status_word = '0;
    status_word[ST_BUSY_BIT]  = (state_q != IDLE);
    status_word[ST_FULL_BIT]  = fifo_full;
    status_word[ST_EMPTY_BIT] = fifo_empty;
    status_word[ST_OVF_BIT]   = ovf_q;
    status_word[ST_CNT_LSB +: ST_CNT_W] = ST_CNT_W'(fifo_count);
  end

  always_comb begin
    wr_ack_d = wr_accept;
    rd_ack_d = rd_accept;
    rd_dat_d = rd_dat_q;
    if (rd_accept) rd_dat_d = rd_is_status ? status_word : 32'h0;
    // Clear-on-read, but an overflow on the same edge must survive.
    ovf_d = ovf_q;
    if (rd_accept && rd_is_status) ovf_d = 1'b0;
    if (ovf_set)                   ovf_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ack_q <= 1'b0;
      rd_ack_q <= 1'b0;
      rd_dat_q <= '0;
      ovf_q    <= 1'b0;
    end else if (sync_reset) begin
      wr_ack_q <= 1'b0;
      rd_ack_q <= 1'b0;
      rd_dat_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ack_q <= wr_ack_d;
      rd_ack_q <= rd_ack_d;
      rd_dat_q <= rd_dat_d;
      ovf_q    <= ovf_d;
    end
  end

  // Transmit FSM. txd_q is loaded with the level of the state being entered,
  // so TXD is glitch-free and changes exactly on bit boundaries.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      txd_q     <= 1'b1;
    end else if (sync_reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      txd_q     <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          txd_q <= 1'b1;
          if (!fifo_empty) begin
            shift_q <= fifo_rdata;
            cnt_q   <= CNT_LOAD;
            txd_q   <= 1'b0;
            state_q <= START;
          end
        end
        START: begin
          if (cnt_q == '0) begin
            cnt_q     <= CNT_LOAD;
            bit_idx_q <= '0;
            txd_q     <= shift_q[0];
            state_q   <= DATA;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        DATA: begin
          if (cnt_q == '0) begin
            cnt_q <= CNT_LOAD;
            if (bit_idx_q == 3'd7) begin
              txd_q   <= 1'b1;
              state_q <= STOP;
            end else begin
              // Present the next bit now; the shifted register holds it at [0].
              shift_q   <= shift_q >> 1;
              txd_q     <= shift_q[1];
              bit_idx_q <= bit_idx_q + 3'd1;
            end
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        STOP: begin
          if (cnt_q == '0) begin
            txd_q   <= 1'b1;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        default: begin
          txd_q   <= 1'b1;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign WB_WR_ACK_O = wr_ack_q;
  assign WB_RD_ACK_O = rd_ack_q;
  assign WB_RD_DAT_O = rd_dat_q;
  assign TXD         = txd_q;

endmodule
